// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mux_arb_pkg
// Brief   : Shared state encoding, stats width and helpers for mux_port_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_t;

    localparam int STAT_W = 16;

    // Saturating increment for the optional statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_port_arbiter_hold_timer.sv
`default_nettype none
// ============================================================================
// Module  : hold_timer
// Brief   : Saturating hold counter; flags when the current owner has used its
//           full hold budget.
// Revision: 1.0 - initial release
// ============================================================================
module hold_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] r_cnt;

    // Saturating at the limit keeps expiry asserted while an owner camps on
    // the port, so a late request from the other side is honoured promptly.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != limit)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = (r_cnt == limit);

endmodule
`default_nettype wire

// File: rtl/mux_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mux_port_arbiter
// Brief   : Two-port round-robin arbiter owning a WIDTH-bit 2:1 mux select,
//           with hold-timeout preemption. Optional MUX_ARB_STATS_EN adds
//           grant/preempt statistics counters.
// Revision: 1.0 - initial release
// ============================================================================
module mux_port_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [WIDTH-1:0]  d0,
    input  logic [WIDTH-1:0]  d1,
    output logic [1:0]        gnt,
    output logic              sel,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    output logic              preempt
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] gnt_cnt0,
    output logic [STAT_W-1:0] gnt_cnt1,
    output logic [STAT_W-1:0] preempt_cnt
`endif
);

    localparam logic [CNT_W-1:0] c_limit = CNT_W'(MAX_HOLD - 1);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_sel;
    logic       r_preempt;
    logic       r_last_srv;
    logic       w_preempt_next;
    logic       w_last_next;
    logic       w_sel_next;
    logic       w_enter;
    logic       w_stay;
    logic       w_expired;

    hold_timer #(
        .CNT_W (CNT_W)
    ) u_hold_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_enter),
        .en      (w_stay),
        .limit   (c_limit),
        .expired (w_expired)
    );

    always_comb begin
        w_next         = r_state;
        w_preempt_next = 1'b0;
        case (r_state)
            IDLE: begin
                case (req)
                    2'b01:   w_next = OWN0;
                    2'b10:   w_next = OWN1;
                    2'b11:   w_next = r_last_srv ? OWN0 : OWN1;
                    default: w_next = IDLE;
                endcase
            end
            OWN0: begin
                if (!req[0]) begin
                    w_next = req[1] ? OWN1 : IDLE;
                end else if (req[1] && w_expired) begin
                    w_next         = OWN1;
                    w_preempt_next = 1'b1;
                end
            end
            OWN1: begin
                if (!req[1]) begin
                    w_next = req[0] ? OWN0 : IDLE;
                end else if (req[0] && w_expired) begin
                    w_next         = OWN0;
                    w_preempt_next = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_enter     = ((w_next == OWN0) || (w_next == OWN1)) && (w_next != r_state);
        w_stay      = ((r_state == OWN0) || (r_state == OWN1)) && (w_next == r_state);
        w_sel_next  = r_sel;
        w_last_next = r_last_srv;
        if (w_enter) begin
            w_sel_next  = (w_next == OWN1);
            w_last_next = (w_next == OWN1);
        end
        // A preempted owner is recorded as last served.
        if (w_preempt_next) begin
            w_last_next = (r_state == OWN1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sel      <= 1'b0;
            r_preempt  <= 1'b0;
            r_last_srv <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_sel      <= w_sel_next;
            r_preempt  <= w_preempt_next;
            r_last_srv <= w_last_next;
        end
    end

    assign gnt       = {r_state == OWN1, r_state == OWN0};
    assign sel       = r_sel;
    assign out_valid = |gnt;
    assign out_data  = r_sel ? d1 : d0;
    assign preempt   = r_preempt;

`ifdef MUX_ARB_STATS_EN
    logic [STAT_W-1:0] r_gnt_cnt0;
    logic [STAT_W-1:0] r_gnt_cnt1;
    logic [STAT_W-1:0] r_preempt_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt_cnt0    <= '0;
            r_gnt_cnt1    <= '0;
            r_preempt_cnt <= '0;
        end else begin
            if (w_enter && (w_next == OWN0)) r_gnt_cnt0 <= sat_inc(r_gnt_cnt0);
            if (w_enter && (w_next == OWN1)) r_gnt_cnt1 <= sat_inc(r_gnt_cnt1);
            if (w_preempt_next)              r_preempt_cnt <= sat_inc(r_preempt_cnt);
        end
    end

    assign gnt_cnt0    = r_gnt_cnt0;
    assign gnt_cnt1    = r_gnt_cnt1;
    assign preempt_cnt = r_preempt_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux_port_arbiter
// Brief   : Scoreboard bench for mux_port_arbiter against an owner/hold-count
//           reference model; directed scenarios followed by random traffic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mux_port_arbiter;

    localparam int WIDTH    = 64;
    localparam int MAX_HOLD = 8;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       req   = 2'b11;
    logic [WIDTH-1:0] d0    = '0;
    logic [WIDTH-1:0] d1    = '0;
    wire  [1:0]       gnt;
    wire              sel;
    wire  [WIDTH-1:0] out_data;
    wire              out_valid;
    wire              preempt;
`ifdef MUX_ARB_STATS_EN
    wire  [15:0]      gnt_cnt0;
    wire  [15:0]      gnt_cnt1;
    wire  [15:0]      preempt_cnt;
`endif

    mux_port_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .d0        (d0),
        .d1        (d1),
        .gnt       (gnt),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .preempt   (preempt)
`ifdef MUX_ARB_STATS_EN
        ,
        .gnt_cnt0    (gnt_cnt0),
        .gnt_cnt1    (gnt_cnt1),
        .preempt_cnt (preempt_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       gnt;
        logic             sel;
        logic             pre;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: who owns the port, how many cycles it has held it.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 1;
    int m_sel   = 0;
    int m_pre   = 0;
    int m_cnt0  = 0;
    int m_cnt1  = 0;
    int m_pcnt  = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic give(input int p);
        m_owner = p;
        m_held  = 1;
        m_last  = p;
        m_sel   = p;
        if (p == 0) m_cnt0++; else m_cnt1++;
    endtask

    task automatic model_step();
        if (reset) begin
            m_owner = -1; m_held = 0; m_last = 1; m_sel = 0; m_pre = 0;
            m_cnt0 = 0; m_cnt1 = 0; m_pcnt = 0;
        end else begin
            m_pre = 0;
            if (m_owner < 0) begin
                if (req == 2'b11)      give(1 - m_last);
                else if (req == 2'b01) give(0);
                else if (req == 2'b10) give(1);
            end else begin
                int i = m_owner;
                int j = 1 - m_owner;
                if (!req[i]) begin
                    if (req[j]) give(j);
                    else m_owner = -1;
                end else if (req[j] && (m_held >= MAX_HOLD)) begin
                    give(j);
                    m_pre  = 1;
                    m_last = i;
                    m_pcnt++;
                end else begin
                    m_held++;
                end
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.gnt  = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        e.sel  = m_sel[0];
        e.pre  = m_pre[0];
        e.data = m_sel[0] ? d1 : d0;
        q.push_back(e);
    endtask

    // Inputs given here are seen by the DUT at the following edge.
    task automatic cycle(input logic r, input logic [1:0] rq, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(posedge clk);
        model_step();
        #1;
        reset = r; req = rq; d0 = a; d1 = b;
        push_exp();
    endtask

    // Both ports want the port; each owner releases right after its grant.
    task automatic fair_cycle();
        @(posedge clk);
        model_step();
        #1;
        reset = 1'b0;
        req = (m_owner == 0) ? 2'b10 : (m_owner == 1) ? 2'b01 : 2'b11;
        push_exp();
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("gnt",       WIDTH'(gnt),       WIDTH'(e.gnt));
            chk("sel",       WIDTH'(sel),       WIDTH'(e.sel));
            chk("preempt",   WIDTH'(preempt),   WIDTH'(e.pre));
            chk("out_valid", WIDTH'(out_valid), WIDTH'(|e.gnt));
            chk("out_data",  out_data,          e.data);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with both requesting, then release: port 0 wins the tie.
        cycle(1'b1, 2'b11, 64'h1111, 64'h2222);
        cycle(1'b1, 2'b11, 64'h1111, 64'h2222);
        cycle(1'b0, 2'b11, 64'h1111, 64'h2222);
        cycle(1'b0, 2'b00, 64'h1111, 64'h2222);
        cycle(1'b0, 2'b00, 64'h1111, 64'h2222);

        // Single requester on port 1.
        repeat (3) cycle(1'b0, 2'b10, 64'h0, 64'hA5A5);
        repeat (3) cycle(1'b0, 2'b00, 64'h0, 64'hA5A5);

        // Back-to-back handoff 0 -> 1.
        repeat (2) cycle(1'b0, 2'b01, 64'h10, 64'h20);
        repeat (3) cycle(1'b0, 2'b11, 64'h10, 64'h20);
        repeat (2) cycle(1'b0, 2'b10, 64'h10, 64'h20);
        repeat (2) cycle(1'b0, 2'b00, 64'h10, 64'h20);

        // Timeout: port 0 holds, port 1 joins after two cycles.
        repeat (2)  cycle(1'b0, 2'b01, 64'h30, 64'h40);
        repeat (12) cycle(1'b0, 2'b11, 64'h30, 64'h40);
        repeat (2)  cycle(1'b0, 2'b00, 64'h30, 64'h40);

        // Saturated hold: long solo ownership, then an immediate preemption.
        repeat (20) cycle(1'b0, 2'b01, 64'h50, 64'h60);
        repeat (3)  cycle(1'b0, 2'b11, 64'h50, 64'h60);
        repeat (2)  cycle(1'b0, 2'b00, 64'h50, 64'h60);

        // Reset in the middle of a transaction.
        repeat (3) cycle(1'b0, 2'b01, 64'h70, 64'h80);
        cycle(1'b1, 2'b01, 64'h70, 64'h80);
        repeat (2) cycle(1'b0, 2'b00, 64'h70, 64'h80);

        // Fairness: 10 single-cycle grants straight after reset.
        cycle(1'b1, 2'b00, 64'h90, 64'hA0);
        cycle(1'b0, 2'b11, 64'h90, 64'hA0);
        repeat (10) fair_cycle();
`ifdef MUX_ARB_STATS_EN
        @(negedge clk);
        chk("gnt_cnt0_fair",    WIDTH'(gnt_cnt0),    WIDTH'(5));
        chk("gnt_cnt1_fair",    WIDTH'(gnt_cnt1),    WIDTH'(5));
        chk("preempt_cnt_fair", WIDTH'(preempt_cnt), WIDTH'(0));
`endif
        cycle(1'b1, 2'b00, 64'h0, 64'h0);
        cycle(1'b0, 2'b00, 64'h0, 64'h0);
`ifdef MUX_ARB_STATS_EN
        @(negedge clk);
        chk("gnt_cnt0_rst",    WIDTH'(gnt_cnt0),    WIDTH'(0));
        chk("gnt_cnt1_rst",    WIDTH'(gnt_cnt1),    WIDTH'(0));
        chk("preempt_cnt_rst", WIDTH'(preempt_cnt), WIDTH'(0));
`endif

        // Random traffic: requests biased high so holds and timeouts occur.
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] rq;
            logic       r;
            rq[0] = ($urandom_range(0, 9) < 7);
            rq[1] = ($urandom_range(0, 9) < 7);
            r     = ($urandom_range(0, 299) == 0);
            cycle(r, rq, {$urandom, $urandom}, {$urandom, $urandom});
        end
        repeat (2) cycle(1'b0, 2'b00, 64'h0, 64'h0);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
`ifdef MUX_ARB_STATS_EN
        chk("gnt_cnt0_end",    WIDTH'(gnt_cnt0),    WIDTH'(m_cnt0));
        chk("gnt_cnt1_end",    WIDTH'(gnt_cnt1),    WIDTH'(m_cnt1));
        chk("preempt_cnt_end", WIDTH'(preempt_cnt), WIDTH'(m_pcnt));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_port_arbiter.md
Name: mux_port_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit 2:1 datapath mux between two requesters, e.g. two pipeline sources contending for the register-file write port.
- Owns the mux select.
- Holds a grant for a multi-cycle transaction.
- Enforces a hold timeout so neither requester can starve the other.
- Drives muxed data plus a valid flag to the downstream stage.

Parameters:
WIDTH, 64, data width of each requester's payload and of out_data
MAX_HOLD, 8, max consecutive grant cycles before preemption when the other port is waiting; legal range 2..255
CNT_W, 8, width of the internal hold counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
req  input  2  req[i] high = requester i wants or keeps the port
d0  input  WIDTH  payload of requester 0
d1  input  WIDTH  payload of requester 1
gnt  output  2  one-hot grant, registered; 2'b00 when idle
sel  output  1  mux select: 0 = d0, 1 = d1; registered
out_data  output  WIDTH  combinational: sel ? d1 : d0
out_valid  output  1  equals |gnt
preempt  output  1  registered one-cycle pulse when a grant was revoked by timeout

Behaviour:
- Interface is fixed: one clock (clk), synchronous active-high reset (reset).
- States: IDLE, OWN0, OWN1. gnt = {state==OWN1, state==OWN0}.
- sel holds its last value in IDLE.
- Reset values:
  - state=IDLE, gnt=00, sel=0, preempt=0, hold_cnt=0.
  - last_srv=1, so port 0 wins the first tie.
- Reset mid-transaction drops the grant at the next edge with no preempt pulse.
- Grant latency: req seen at edge N causes gnt at edge N+1 (one cycle). Grant is never combinational from req.
- IDLE transitions:
  - req==01 -> OWN0.
  - req==10 -> OWN1.
  - req==11 -> port != last_srv.
  - req==00 -> stay in IDLE.
- OWNi, release: owner drops req[i] -> leave OWNi next edge.
  - If the other req is high, go directly to OWNj with no idle bubble.
  - Otherwise go to IDLE.
- OWNi, keep: owner holds req[i] -> stay in OWNi; hold_cnt increments, saturating.
- Preemption:
  - Fires when hold_cnt == MAX_HOLD-1 and req[j] is high at an edge.
  - Next state OWNj; preempt=1 for exactly that cycle.
  - last_srv=i.
- No preempt if the other port is not requesting. The owner may then keep the port indefinitely, with hold_cnt saturated.
- hold_cnt and last_srv update on every grant change:
  - hold_cnt resets to 0 on entering any OWN state.
  - last_srv records the port being granted.
- sel updates on the same edge as gnt, so out_data and out_valid are coherent with gnt every cycle.
- gnt is never 11. Any illegal state encoding recovers to IDLE next edge.
- Dropping a req in the same cycle it is granted is legal: a 1-cycle transaction.

Optional Feature:
- Macro: MUX_ARB_STATS_EN.
- When defined:
  - Adds outputs gnt_cnt0 and gnt_cnt1 (16 bits each) and preempt_cnt (16 bits).
  - Each counts grant entries or preemptions, saturates at 16'hFFFF, and clears on reset.
- When undefined:
  - The ports and counters do not exist.
  - Arbitration behaviour is identical.

Decomposition:
- Package mux_arb_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE=2'b00, OWN0=2'b01, OWN1=2'b10}.
  - localparam STAT_W=16.
- Sub-module hold_timer (clk, reset, clear, en, limit, expired) holds the saturating hold counter and the compare against MAX_HOLD-1.
- Next-state logic, grant/sel registers and the data mux stay in mux_port_arbiter.

Test Plan:
- Reset:
  - Stimulus: reset=1 for 2 cycles with req=11, then release.
  - Required: gnt=00 and sel=0 during reset; one cycle after release gnt=01 (tie goes to port 0); out_data=d0.
- Single requester:
  - Stimulus: req=10, d1=64'hA5A5, hold 3 cycles, drop.
  - Required: gnt=10, sel=1 and out_data=64'hA5A5 for 3 cycles; then gnt=00, out_valid=0.
- Back-to-back handoff:
  - Stimulus: port 0 owns, req=11; drop req[0].
  - Required: next cycle gnt=10 with no IDLE cycle; preempt stays 0.
- Timeout with MAX_HOLD=8:
  - Stimulus: req[0] held continuously from grant, req[1] raised at cycle 2.
  - Required: after 8 grant cycles gnt switches 01->10 and preempt=1 for exactly one cycle.
- Fairness:
  - Stimulus: req=11 constant with 1-cycle transactions (each owner drops req for one cycle after grant).
  - Required: grants alternate 01,10,01,10; no port granted twice in a row.
- Stats, only with MUX_ARB_STATS_EN:
  - Stimulus: run the fairness test for 10 grants.
  - Required: gnt_cnt0=5, gnt_cnt1=5, preempt_cnt=0; all counters clear to 0 on reset.
